// File: rtl/pdp8_pkg.sv
// Shared widths, FSM/requester enums and the memory command payload for the arbiter.
package pdp8_pkg;

  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DATA_WIDTH = 12;
  localparam int unsigned CNT_WIDTH  = 4;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_EXU = 1'b1
  } requester_t;

  // Memory-side command; all-zero whenever no access is in flight
  typedef struct packed {
    logic  rd;
    logic  wr;
    addr_t addr;
    data_t wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of IFU, EXU and memory-side signals around the arbiter.
interface mem_arbiter_if;
  import pdp8_pkg::*;

  logic  ifu_rd_req;
  addr_t ifu_rd_addr;
  data_t ifu_rd_data;
  logic  ifu_rd_done;

  logic  exu_rd_req;
  logic  exu_wr_req;
  addr_t exu_addr;
  data_t exu_wr_data;
  data_t exu_rd_data;
  logic  exu_done;

  logic  mem_rd_req;
  logic  mem_wr_req;
  addr_t mem_addr;
  data_t mem_wr_data;
  data_t mem_rd_data;

  // Arbiter side
  modport slave (
    input  ifu_rd_req, ifu_rd_addr,
    input  exu_rd_req, exu_wr_req, exu_addr, exu_wr_data,
    input  mem_rd_data,
    output ifu_rd_data, ifu_rd_done,
    output exu_rd_data, exu_done,
    output mem_rd_req, mem_wr_req, mem_addr, mem_wr_data
  );

  // Requester / memory-model side
  modport master (
    output ifu_rd_req, ifu_rd_addr,
    output exu_rd_req, exu_wr_req, exu_addr, exu_wr_data,
    output mem_rd_data,
    input  ifu_rd_data, ifu_rd_done,
    input  exu_rd_data, exu_done,
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_data
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick between IFU and EXU with the last_grant register.
module mem_arb_rr
  import pdp8_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       arb_en,
  input  logic       ifu_req,
  input  logic       exu_req,
  output logic       grant_vld_c,
  output requester_t grant_c
);

  requester_t last_grant_q;
  requester_t last_grant_d;

  // Pick winner: on a tie the requester not granted last wins
  always_comb begin
    grant_vld_c  = arb_en && (ifu_req || exu_req);
    grant_c      = REQ_IFU;
    if (ifu_req && exu_req) begin
      grant_c = (last_grant_q == REQ_EXU) ? REQ_IFU : REQ_EXU;
    end else if (exu_req) begin
      grant_c = REQ_EXU;
    end
    last_grant_d = grant_vld_c ? grant_c : last_grant_q;
  end

  // Reset to EXU so that IFU wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= REQ_EXU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: IFU reads and EXU reads/writes share one memory
// with a fixed MEM_LATENCY access, one transaction in flight at a time.
module mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
)
(
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  arb_state_t           state_q,    state_d;
  logic [CNT_WIDTH-1:0] cnt_q,      cnt_d;
  requester_t           owner_q,    owner_d;
  mem_cmd_t             mem_q,      mem_d;
  logic                 ifu_done_q, ifu_done_d;
  logic                 exu_done_q, exu_done_d;
  data_t                ifu_data_q, ifu_data_d;
  data_t                exu_data_q, exu_data_d;

  logic       exu_req_c;
  logic       grant_vld_c;
  requester_t grant_c;

  assign exu_req_c = bus.exu_rd_req | bus.exu_wr_req;

  mem_arb_rr u_rr (
    .clk         (clk),
    .reset_n     (reset_n),
    .arb_en      (state_q == IDLE),
    .ifu_req     (bus.ifu_rd_req),
    .exu_req     (exu_req_c),
    .grant_vld_c (grant_vld_c),
    .grant_c     (grant_c)
  );

  // Next-state, latency counter, memory command and completion outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    mem_d      = mem_q;
    ifu_done_d = 1'b0;
    exu_done_d = 1'b0;
    ifu_data_d = ifu_data_q;
    exu_data_d = exu_data_q;

    unique case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          state_d = ACCESS;
          cnt_d   = CNT_WIDTH'(MEM_LATENCY);
          owner_d = grant_c;
          if (grant_c == REQ_IFU) begin
            mem_d = '{rd: 1'b1, wr: 1'b0, addr: bus.ifu_rd_addr, wdata: '0};
          end else if (bus.exu_wr_req) begin
            // Write takes precedence when EXU raises both read and write
            mem_d = '{rd: 1'b0, wr: 1'b1, addr: bus.exu_addr, wdata: bus.exu_wr_data};
          end else begin
            mem_d = '{rd: 1'b1, wr: 1'b0, addr: bus.exu_addr, wdata: '0};
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = COMPLETE;
          mem_d   = '0;
          if (owner_q == REQ_IFU) begin
            ifu_done_d = 1'b1;
            if (mem_q.rd) begin
              ifu_data_d = bus.mem_rd_data;
            end
          end else begin
            exu_done_d = 1'b1;
            if (mem_q.rd) begin
              exu_data_d = bus.mem_rd_data;
            end
          end
        end
      end
      COMPLETE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        mem_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= REQ_EXU;
      mem_q      <= '0;
      ifu_done_q <= 1'b0;
      exu_done_q <= 1'b0;
      ifu_data_q <= '0;
      exu_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      mem_q      <= mem_d;
      ifu_done_q <= ifu_done_d;
      exu_done_q <= exu_done_d;
      ifu_data_q <= ifu_data_d;
      exu_data_q <= exu_data_d;
    end
  end

  assign bus.mem_rd_req  = mem_q.rd;
  assign bus.mem_wr_req  = mem_q.wr;
  assign bus.mem_addr    = mem_q.addr;
  assign bus.mem_wr_data = mem_q.wdata;
  assign bus.ifu_rd_done = ifu_done_q;
  assign bus.ifu_rd_data = ifu_data_q;
  assign bus.exu_done    = exu_done_q;
  assign bus.exu_rd_data = exu_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table at MEM_LATENCY=1 plus
// hand-written multi-cycle and reset sequences at MEM_LATENCY=3.
module tb_mem_arbiter;
  import pdp8_pkg::*;

  typedef struct packed {
    logic  mrq;
    logic  mwq;
    addr_t maddr;
    data_t mwd;
    logic  idone;
    data_t idata;
    logic  edone;
    data_t edata;
  } outs_t;

  typedef struct {
    logic  ireq;
    addr_t iaddr;
    logic  erd;
    logic  ewr;
    addr_t eaddr;
    data_t ewd;
    data_t mrd;
    outs_t exp;
  } vec_t;

  localparam int NVEC = 26;

  logic clk = 1'b0;
  logic rst1_n;
  logic rst3_n;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  mem_arbiter_if bus1();
  mem_arbiter_if bus3();

  mem_arbiter #(.MEM_LATENCY(1)) dut1 (.clk(clk), .reset_n(rst1_n), .bus(bus1));
  mem_arbiter #(.MEM_LATENCY(3)) dut3 (.clk(clk), .reset_n(rst3_n), .bus(bus3));

  function automatic outs_t mk_out(input logic mrq, input logic mwq, input addr_t ma,
                                   input data_t mwd, input logic id, input data_t idat,
                                   input logic ed, input data_t edat);
    outs_t o;
    o.mrq = mrq; o.mwq = mwq; o.maddr = ma; o.mwd = mwd;
    o.idone = id; o.idata = idat; o.edone = ed; o.edata = edat;
    return o;
  endfunction

  function automatic vec_t mk_vec(input logic ireq, input addr_t iaddr, input logic erd,
                                  input logic ewr, input addr_t eaddr, input data_t ewd,
                                  input data_t mrd, input outs_t exp);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.erd = erd; v.ewr = ewr;
    v.eaddr = eaddr; v.ewd = ewd; v.mrd = mrd; v.exp = exp;
    return v;
  endfunction

  function automatic outs_t sample1();
    return mk_out(bus1.mem_rd_req, bus1.mem_wr_req, bus1.mem_addr, bus1.mem_wr_data,
                  bus1.ifu_rd_done, bus1.ifu_rd_data, bus1.exu_done, bus1.exu_rd_data);
  endfunction

  function automatic outs_t sample3();
    return mk_out(bus3.mem_rd_req, bus3.mem_wr_req, bus3.mem_addr, bus3.mem_wr_data,
                  bus3.ifu_rd_done, bus3.ifu_rd_data, bus3.exu_done, bus3.exu_rd_data);
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (mrq,mwq,maddr,mwd,idone,idata,edone,edata)",
               name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive1(input vec_t v);
    bus1.ifu_rd_req  = v.ireq;
    bus1.ifu_rd_addr = v.iaddr;
    bus1.exu_rd_req  = v.erd;
    bus1.exu_wr_req  = v.ewr;
    bus1.exu_addr    = v.eaddr;
    bus1.exu_wr_data = v.ewd;
    bus1.mem_rd_data = v.mrd;
  endtask

  task automatic idle3();
    bus3.ifu_rd_req  = 1'b0;
    bus3.ifu_rd_addr = '0;
    bus3.exu_rd_req  = 1'b0;
    bus3.exu_wr_req  = 1'b0;
    bus3.exu_addr    = '0;
    bus3.exu_wr_data = '0;
    bus3.mem_rd_data = '0;
  endtask

  task automatic fill_vectors();
    outs_t z;
    z = '0;
    // Both requesters held: IFU read 0100, EXU write 0300/1234 -> IFU, EXU, IFU, EXU
    vecs[0]  = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o5555,
                      mk_out(1'b1, 1'b0, 12'o0100, 12'o0, 1'b0, 12'o0, 1'b0, 12'o0));
    vecs[1]  = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o5555,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b1, 12'o5555, 1'b0, 12'o0));
    vecs[2]  = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o5555,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o5555, 1'b0, 12'o0));
    vecs[3]  = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o5555,
                      mk_out(1'b0, 1'b1, 12'o0300, 12'o1234, 1'b0, 12'o5555, 1'b0, 12'o0));
    vecs[4]  = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o5555,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o5555, 1'b1, 12'o0));
    vecs[5]  = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o5555,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o5555, 1'b0, 12'o0));
    vecs[6]  = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o6666,
                      mk_out(1'b1, 1'b0, 12'o0100, 12'o0, 1'b0, 12'o5555, 1'b0, 12'o0));
    vecs[7]  = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o6666,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b1, 12'o6666, 1'b0, 12'o0));
    vecs[8]  = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o6666,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o6666, 1'b0, 12'o0));
    vecs[9]  = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o6666,
                      mk_out(1'b0, 1'b1, 12'o0300, 12'o1234, 1'b0, 12'o6666, 1'b0, 12'o0));
    vecs[10] = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o6666,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o6666, 1'b1, 12'o0));
    vecs[11] = mk_vec(1'b1, 12'o0100, 1'b0, 1'b1, 12'o0300, 12'o1234, 12'o6666,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o6666, 1'b0, 12'o0));
    // Lone IFU read 0200 returning 7402
    vecs[12] = mk_vec(1'b1, 12'o0200, 1'b0, 1'b0, 12'o0, 12'o0, 12'o7402,
                      mk_out(1'b1, 1'b0, 12'o0200, 12'o0, 1'b0, 12'o6666, 1'b0, 12'o0));
    vecs[13] = mk_vec(1'b1, 12'o0200, 1'b0, 1'b0, 12'o0, 12'o0, 12'o7402,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b1, 12'o7402, 1'b0, 12'o0));
    vecs[14] = mk_vec(1'b1, 12'o0200, 1'b0, 1'b0, 12'o0, 12'o0, 12'o7402,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o7402, 1'b0, 12'o0));
    // EXU read+write together is a write; exu_rd_data stays put
    vecs[15] = mk_vec(1'b0, 12'o0, 1'b1, 1'b1, 12'o0400, 12'o0777, 12'o1111,
                      mk_out(1'b0, 1'b1, 12'o0400, 12'o0777, 1'b0, 12'o7402, 1'b0, 12'o0));
    vecs[16] = mk_vec(1'b0, 12'o0, 1'b1, 1'b1, 12'o0400, 12'o0777, 12'o1111,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o7402, 1'b1, 12'o0));
    vecs[17] = mk_vec(1'b0, 12'o0, 1'b1, 1'b1, 12'o0400, 12'o0777, 12'o1111,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o7402, 1'b0, 12'o0));
    // EXU read 0055 -> 2222
    vecs[18] = mk_vec(1'b0, 12'o0, 1'b1, 1'b0, 12'o0055, 12'o0, 12'o2222,
                      mk_out(1'b1, 1'b0, 12'o0055, 12'o0, 1'b0, 12'o7402, 1'b0, 12'o0));
    vecs[19] = mk_vec(1'b0, 12'o0, 1'b1, 1'b0, 12'o0055, 12'o0, 12'o2222,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o7402, 1'b1, 12'o2222));
    vecs[20] = mk_vec(1'b0, 12'o0, 1'b1, 1'b0, 12'o0055, 12'o0, 12'o2222,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o7402, 1'b0, 12'o2222));
    // EXU write 0060/0001 must not disturb either read-data register
    vecs[21] = mk_vec(1'b0, 12'o0, 1'b0, 1'b1, 12'o0060, 12'o0001, 12'o3333,
                      mk_out(1'b0, 1'b1, 12'o0060, 12'o0001, 1'b0, 12'o7402, 1'b0, 12'o2222));
    vecs[22] = mk_vec(1'b0, 12'o0, 1'b0, 1'b1, 12'o0060, 12'o0001, 12'o3333,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o7402, 1'b1, 12'o2222));
    vecs[23] = mk_vec(1'b0, 12'o0, 1'b0, 1'b1, 12'o0060, 12'o0001, 12'o3333,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o7402, 1'b0, 12'o2222));
    // No requests: stay idle
    vecs[24] = mk_vec(1'b0, 12'o0, 1'b0, 1'b0, 12'o0, 12'o0, 12'o4444,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o7402, 1'b0, 12'o2222));
    vecs[25] = mk_vec(1'b0, 12'o0, 1'b0, 1'b0, 12'o0, 12'o0, 12'o4444,
                      mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o7402, 1'b0, 12'o2222));
    if (z != '0) $display("unexpected");
  endtask

  initial begin
    outs_t rd3;
    outs_t zero;
    int    lat;
    int    strobes;
    bit    found;

    zero = '0;
    fill_vectors();
    drive1(mk_vec(1'b0, 12'o0, 1'b0, 1'b0, 12'o0, 12'o0, 12'o0, zero));
    idle3();
    rst1_n = 1'b0;
    rst3_n = 1'b0;

    #2;
    check("reset_l1", sample1(), zero);
    check("reset_l3", sample3(), zero);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    @(posedge clk);
    #1;

    // Cycle table at MEM_LATENCY=1
    for (int i = 0; i < NVEC; i++) begin
      drive1(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), sample1(), vecs[i].exp);
    end

    // EXU read 0055 -> 4321 at MEM_LATENCY=3, address disturbed mid-access
    bus3.exu_rd_req  = 1'b1;
    bus3.exu_addr    = 12'o0055;
    bus3.mem_rd_data = 12'o4321;
    rd3 = mk_out(1'b1, 1'b0, 12'o0055, 12'o0, 1'b0, 12'o0, 1'b0, 12'o0);
    @(posedge clk); #1;
    check("l3_rd_acc1", sample3(), rd3);
    bus3.exu_addr    = 12'o0777;
    bus3.exu_wr_data = 12'o7777;
    @(posedge clk); #1;
    check("l3_rd_acc2", sample3(), rd3);
    @(posedge clk); #1;
    check("l3_rd_acc3", sample3(), rd3);
    @(posedge clk); #1;
    check("l3_rd_done", sample3(), mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o0, 1'b1, 12'o4321));
    @(posedge clk); #1;
    check("l3_rd_idle", sample3(), mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o0, 1'b0, 12'o4321));
    idle3();

    // Reset in the second ACCESS cycle abandons the IFU read
    bus3.ifu_rd_req  = 1'b1;
    bus3.ifu_rd_addr = 12'o0100;
    bus3.mem_rd_data = 12'o1357;
    rd3 = mk_out(1'b1, 1'b0, 12'o0100, 12'o0, 1'b0, 12'o0, 1'b0, 12'o4321);
    @(posedge clk); #1;
    check("l3_rst_acc1", sample3(), rd3);
    @(posedge clk); #2;
    check("l3_rst_acc2", sample3(), rd3);
    rst3_n = 1'b0;
    idle3();
    #1;
    check("l3_rst_async", sample3(), zero);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst3_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("l3_no_done%0d", k), sample3(), zero);
    end

    // Fresh IFU read 0200 -> 7402 completes four edges after it is presented
    bus3.ifu_rd_req  = 1'b1;
    bus3.ifu_rd_addr = 12'o0200;
    bus3.mem_rd_data = 12'o7402;
    lat     = 0;
    strobes = 0;
    found   = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(posedge clk); #1;
      if (bus3.mem_rd_req && bus3.mem_addr == 12'o0200) strobes++;
      if (bus3.ifu_rd_done) begin
        found = 1'b1;
        lat   = k;
      end
    end
    check_v("l3_fresh_latency", lat, 4);
    check_v("l3_fresh_strobes", strobes, 3);
    check("l3_fresh_done", sample3(), mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b1, 12'o7402, 1'b0, 12'o0));
    @(posedge clk); #1;
    check("l3_fresh_idle", sample3(), mk_out(1'b0, 1'b0, 12'o0, 12'o0, 1'b0, 12'o7402, 1'b0, 12'o0));
    idle3();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LATENCY, 1, cycles a memory request is held before mem_rd_data is valid or the write is committed; legal range 1..15.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ifu_rd_req  in  1  IFU read request, level, held until ifu_rd_done.
REQ-005 ifu_rd_addr  in  `ADDR_WIDTH  IFU read address, stable while ifu_rd_req high.
REQ-006 ifu_rd_data  out  `DATA_WIDTH  IFU read data, valid when ifu_rd_done high, then held.
REQ-007 ifu_rd_done  out  1  one-cycle IFU completion pulse.
REQ-008 exu_rd_req, exu_wr_req  in  1 each  EXU read or write request, level, held until exu_done.
REQ-009 exu_addr, exu_wr_data  in  `ADDR_WIDTH, `DATA_WIDTH  EXU address and write data, stable while a request is high.
REQ-010 exu_rd_data  out  `DATA_WIDTH  EXU read data, valid when exu_done high, then held.
REQ-011 exu_done  out  1  one-cycle EXU completion pulse, read or write.
REQ-012 mem_rd_req, mem_wr_req  out  1 each  memory read or write strobe.
REQ-013 mem_addr, mem_wr_data  out  `ADDR_WIDTH, `DATA_WIDTH  memory address and write data.
REQ-014 mem_rd_data  in  `DATA_WIDTH  memory read data, sampled on last ACCESS cycle.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, COMPLETE, with one transaction in flight at most.
REQ-016 IDLE: no request -> stay; any request -> latch winner, address, write data and operation, load counter with MEM_LATENCY, go ACCESS next edge.
REQ-017 Arbitration SHALL be 2-way round-robin: on contention the requester not granted last wins; last_grant resets to EXU, so IFU wins the first tie.
REQ-018 Uncontended request SHALL be granted in the IDLE cycle it is first seen; last_grant updates on every grant.
REQ-019 ACCESS: mem_rd_req or mem_wr_req high with latched mem_addr/mem_wr_data for exactly MEM_LATENCY cycles; counter decrements each cycle; at 1 capture mem_rd_data (reads) and go COMPLETE.
REQ-020 COMPLETE: pulse the winner's done for exactly one cycle with its read data updated the same cycle; go IDLE; requests not sampled in COMPLETE.
REQ-021 Requester SHALL deassert or change its request at the edge ending its done cycle; next IDLE cycle samples fresh values.
REQ-022 Latency: request seen in IDLE cycle T -> memory strobe T+1..T+MEM_LATENCY -> done at T+MEM_LATENCY+1; back-to-back throughput one access per MEM_LATENCY+2 cycles.
REQ-023 exu_rd_req and exu_wr_req both high SHALL be treated as a write; exu_rd_data unchanged.
REQ-024 Writes SHALL leave exu_rd_data and ifu_rd_data unchanged.
REQ-025 Outside ACCESS, mem_rd_req, mem_wr_req, mem_addr and mem_wr_data SHALL be 0.
REQ-026 Input changes during ACCESS SHALL not affect the transaction in flight.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, counter 0, last_grant EXU, and every output 0.
REQ-028 Reset during ACCESS or COMPLETE SHALL abandon the transaction with no done pulse after release.
REQ-029 First arbitration SHALL occur on the first rising edge with reset_n high.

Structure
REQ-030 pdp8_pkg SHALL hold `ADDR_WIDTH/`DATA_WIDTH (12), typedef arb_state_t {IDLE, ACCESS, COMPLETE} and typedef requester_t {REQ_IFU, REQ_EXU}.
REQ-031 One sub-module, mem_arb_rr, SHALL implement round-robin pick and the last_grant register; FSM, counter and muxing stay in mem_arbiter.

Verification
REQ-032 MEM_LATENCY=1; IFU read addr 0o0200, mem_rd_data 0o7402 -> mem_rd_req with mem_addr 0o0200 at T+1; ifu_rd_done, ifu_rd_data 0o7402 at T+2.
REQ-033 After reset, IFU read 0o0100 and EXU write 0o0300/0o1234 same cycle -> IFU served first; then mem_wr_req, mem_addr 0o0300, mem_wr_data 0o1234; exu_done once.
REQ-034 Both requesters held for 4 transactions -> grant order IFU, EXU, IFU, EXU; each done exactly once per transaction.
REQ-035 MEM_LATENCY=3; EXU read 0o0055, mem_rd_data 0o4321 -> mem_rd_req high 3 cycles; exu_done, exu_rd_data 0o4321 at T+4.
REQ-036 reset_n low in 2nd ACCESS cycle (MEM_LATENCY=3) -> all outputs 0 same cycle; no done after release; fresh IFU read then completes normally.
REQ-037 exu_rd_req and exu_wr_req high, exu_wr_data 0o0777 -> mem_wr_req only; exu_rd_data unchanged.
